// File: rtl/contador_modulo.sv
// contador_modulo: parametrised modulo-N up/down counter.
// Steps on the rising edge of nxt, with synchronous clear and load, wrap or
// saturate at the limits, and one-cycle overflow/underflow pulses.
module contador_modulo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = (2**WIDTH) - 1,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nxt,
  input  logic             dir,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] cuenta,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             und
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic             nxt_q;
  logic             step;
  logic [WIDTH-1:0] cuenta_d;
  logic             ovf_d;
  logic             und_d;

  // A step is the 0->1 transition of nxt.
  assign step = nxt & ~nxt_q;

  // Next-count selection; limits are compared before any arithmetic so the
  // count never passes through a value above MAX.
  always_comb begin
    cuenta_d = cuenta;
    ovf_d    = 1'b0;
    und_d    = 1'b0;
    if (clr) begin
      cuenta_d = ZERO_V;
    end else if (ld) begin
      cuenta_d = (ld_val > MAX_V) ? MAX_V : ld_val;
    end else if (step) begin
      if (dir) begin
        if (cuenta == MAX_V) begin
          ovf_d    = 1'b1;
          cuenta_d = WRAP ? ZERO_V : MAX_V;
        end else begin
          cuenta_d = cuenta + ONE_V;
        end
      end else begin
        if (cuenta == ZERO_V) begin
          und_d    = 1'b1;
          cuenta_d = WRAP ? MAX_V : ZERO_V;
        end else begin
          cuenta_d = cuenta - ONE_V;
        end
      end
    end
  end

  // State register; nxt_q resets high so a held nxt at release is not a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= ZERO_V;
      nxt_q  <= 1'b1;
      ovf    <= 1'b0;
      und    <= 1'b0;
    end else begin
      cuenta <= cuenta_d;
      nxt_q  <= nxt;
      ovf    <= ovf_d;
      und    <= und_d;
    end
  end

  // Limit flags decoded straight from the count register.
  assign empty = (cuenta == ZERO_V);
  assign full  = (cuenta == MAX_V);

endmodule

// File: tb/tb_contador_modulo.sv
// Bench for contador_modulo: two instances (W=2/MAX=3/saturate and
// W=4/MAX=9/wrap) checked every cycle against an arithmetic model, plus
// directed literal expectations.
module tb_contador_modulo;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  // Instance A: WIDTH=2, MAX=3, WRAP=0
  logic       a_nxt = 1'b1, a_dir = 1'b1, a_clr = 1'b0, a_ld = 1'b0;
  logic [1:0] a_ld_val = 2'd0;
  logic [1:0] a_cuenta;
  logic       a_empty, a_full, a_ovf, a_und;

  // Instance B: WIDTH=4, MAX=9, WRAP=1
  logic       b_nxt = 1'b1, b_dir = 1'b1, b_clr = 1'b0, b_ld = 1'b0;
  logic [3:0] b_ld_val = 4'd0;
  logic [3:0] b_cuenta;
  logic       b_empty, b_full, b_ovf, b_und;

  contador_modulo #(.WIDTH(2), .MAX(3), .WRAP(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .nxt(a_nxt), .dir(a_dir), .clr(a_clr), .ld(a_ld),
    .ld_val(a_ld_val), .cuenta(a_cuenta), .empty(a_empty), .full(a_full),
    .ovf(a_ovf), .und(a_und)
  );

  contador_modulo #(.WIDTH(4), .MAX(9), .WRAP(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .nxt(b_nxt), .dir(b_dir), .clr(b_clr), .ld(b_ld),
    .ld_val(b_ld_val), .cuenta(b_cuenta), .empty(b_empty), .full(b_full),
    .ovf(b_ovf), .und(b_und)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference behaviour in plain integer arithmetic.
  function automatic void model_step(
    input int cnt, input int max, input bit wrap, input bit step, input bit up,
    input bit clr, input bit ld, input int ldv,
    output int ncnt, output bit novf, output bit nund);
    ncnt = cnt; novf = 1'b0; nund = 1'b0;
    if (clr) ncnt = 0;
    else if (ld) ncnt = (ldv > max) ? max : ldv;
    else if (step && up) begin
      novf = (cnt == max);
      if (wrap) ncnt = (cnt + 1) % (max + 1);
      else      ncnt = (cnt + 1 > max) ? max : cnt + 1;
    end else if (step) begin
      nund = (cnt == 0);
      if (wrap) ncnt = (cnt + max) % (max + 1);
      else      ncnt = (cnt - 1 < 0) ? 0 : cnt - 1;
    end
  endfunction

  int ma_cnt = 0, mb_cnt = 0;
  bit ma_ovf = 1'b0, ma_und = 1'b0, ma_prev = 1'b1;
  bit mb_ovf = 1'b0, mb_und = 1'b0, mb_prev = 1'b1;

  // Model state advances on the same events as the design.
  always @(posedge clk or negedge rst_n) begin
    int  c;
    bit  o, u;
    if (!rst_n) begin
      ma_cnt <= 0; ma_ovf <= 1'b0; ma_und <= 1'b0; ma_prev <= 1'b1;
      mb_cnt <= 0; mb_ovf <= 1'b0; mb_und <= 1'b0; mb_prev <= 1'b1;
    end else begin
      model_step(ma_cnt, 3, 1'b0, a_nxt && !ma_prev, a_dir, a_clr, a_ld,
                 int'(a_ld_val), c, o, u);
      ma_cnt <= c; ma_ovf <= o; ma_und <= u; ma_prev <= a_nxt;
      model_step(mb_cnt, 9, 1'b1, b_nxt && !mb_prev, b_dir, b_clr, b_ld,
                 int'(b_ld_val), c, o, u);
      mb_cnt <= c; mb_ovf <= o; mb_und <= u; mb_prev <= b_nxt;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("a_cuenta", int'(a_cuenta), ma_cnt);
    chk("a_empty",  int'(a_empty),  int'(ma_cnt == 0));
    chk("a_full",   int'(a_full),   int'(ma_cnt == 3));
    chk("a_ovf",    int'(a_ovf),    int'(ma_ovf));
    chk("a_und",    int'(a_und),    int'(ma_und));
    chk("b_cuenta", int'(b_cuenta), mb_cnt);
    chk("b_empty",  int'(b_empty),  int'(mb_cnt == 0));
    chk("b_full",   int'(b_full),   int'(mb_cnt == 9));
    chk("b_ovf",    int'(b_ovf),    int'(mb_ovf));
    chk("b_und",    int'(b_und),    int'(mb_und));
  end

  // One clean 0->1 on nxt; returns on the falling edge after the step edge.
  task automatic edge_a(input bit up);
    @(negedge clk); a_nxt = 1'b0;
    @(negedge clk); a_nxt = 1'b1; a_dir = up;
    @(negedge clk);
  endtask

  task automatic edge_b(input bit up);
    @(negedge clk); b_nxt = 1'b0;
    @(negedge clk); b_nxt = 1'b1; b_dir = up;
    @(negedge clk);
  endtask

  int a_up_cnt[6] = '{1, 2, 3, 3, 3, 3};
  int a_up_ovf[6] = '{0, 0, 0, 1, 1, 1};
  int a_up_ful[6] = '{0, 0, 1, 1, 1, 1};
  int a_dn_cnt[5] = '{2, 1, 0, 0, 0};
  int a_dn_und[5] = '{0, 0, 0, 1, 1};
  int a_dn_emp[5] = '{0, 0, 1, 1, 1};

  initial begin
    // Reset with nxt already high on both instances.
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_cuenta", int'(a_cuenta), 0);
    chk("rst_a_empty",  int'(a_empty),  1);
    chk("rst_b_cuenta", int'(b_cuenta), 0);
    chk("rst_b_full",   int'(b_full),   0);
    chk("rst_b_ovf",    int'(b_ovf),    0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_nxt_no_step", int'(b_cuenta), 0);

    // A: saturating up then down.
    for (int i = 0; i < 6; i++) begin
      edge_a(1'b1);
      chk("a_up_cuenta", int'(a_cuenta), a_up_cnt[i]);
      chk("a_up_ovf",    int'(a_ovf),    a_up_ovf[i]);
      chk("a_up_full",   int'(a_full),   a_up_ful[i]);
    end
    for (int i = 0; i < 5; i++) begin
      edge_a(1'b0);
      chk("a_dn_cuenta", int'(a_cuenta), a_dn_cnt[i]);
      chk("a_dn_und",    int'(a_und),    a_dn_und[i]);
      chk("a_dn_empty",  int'(a_empty),  a_dn_emp[i]);
    end

    // B: first edge after release, then nxt held high for 10 cycles.
    edge_b(1'b1);
    chk("b_first_step", int'(b_cuenta), 1);
    @(negedge clk); b_nxt = 1'b0;
    @(negedge clk); b_nxt = 1'b1;
    repeat (10) @(negedge clk);
    chk("b_hold_one_step", int'(b_cuenta), 2);
    b_nxt = 1'b0; b_clr = 1'b1;
    @(negedge clk); b_clr = 1'b0;
    chk("b_clr", int'(b_cuenta), 0);

    // B: wrap modulo 10.
    for (int i = 0; i < 11; i++) begin
      edge_b(1'b1);
      chk("b_up_cuenta", int'(b_cuenta), (i + 1) % 10);
      chk("b_up_ovf",    int'(b_ovf),    int'(i == 9));
    end
    edge_b(1'b0);
    chk("b_dn_to_zero", int'(b_cuenta), 0);
    edge_b(1'b0);
    chk("b_dn_wrap_cuenta", int'(b_cuenta), 9);
    chk("b_dn_wrap_und",    int'(b_und),    1);
    chk("b_dn_wrap_full",   int'(b_full),   1);
    @(negedge clk);
    chk("b_und_one_cycle", int'(b_und), 0);

    // B: priority clr > ld > step.
    b_nxt = 1'b0; b_ld = 1'b1; b_ld_val = 4'd5;
    @(negedge clk); b_ld = 1'b0;
    chk("b_ld5", int'(b_cuenta), 5);
    b_clr = 1'b1; b_ld = 1'b1; b_ld_val = 4'd7; b_nxt = 1'b1; b_dir = 1'b1;
    @(negedge clk);
    chk("b_prio_clr_cuenta", int'(b_cuenta), 0);
    chk("b_prio_clr_ovf",    int'(b_ovf),    0);
    chk("b_prio_clr_und",    int'(b_und),    0);
    b_clr = 1'b0; b_ld = 1'b0; b_nxt = 1'b0;
    @(negedge clk); b_ld = 1'b1; b_ld_val = 4'd7; b_nxt = 1'b1;
    @(negedge clk);
    chk("b_prio_ld", int'(b_cuenta), 7);
    b_ld_val = 4'd12;
    @(negedge clk);
    chk("b_ld_clamp", int'(b_cuenta), 9);
    chk("b_ld_clamp_full", int'(b_full), 1);
    b_ld = 1'b0; b_nxt = 1'b0;
    @(negedge clk); b_ld = 1'b1; b_ld_val = 4'd3; b_nxt = 1'b1;
    @(negedge clk);
    chk("b_ld_over_step_cuenta", int'(b_cuenta), 3);
    chk("b_ld_over_step_ovf",    int'(b_ovf),    0);

    // B: asynchronous reset between edges.
    b_ld_val = 4'd6; b_nxt = 1'b0;
    @(negedge clk); b_ld = 1'b0;
    chk("b_ld6", int'(b_cuenta), 6);
    @(posedge clk);
    #2 rst_n = 1'b0; b_nxt = 1'b1; b_dir = 1'b1;
    #1;
    chk("async_rst_cuenta", int'(b_cuenta), 0);
    chk("async_rst_empty",  int'(b_empty),  1);
    chk("async_rst_full",   int'(b_full),   0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("no_step_after_release", int'(b_cuenta), 0);
    edge_b(1'b1);
    chk("step_after_fresh_edge", int'(b_cuenta), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
